arb_weight_tracker: RTL and testbench
=====================================

Name: arb_weight_tracker

Overview:
- Sequential stage directly downstream of the combinational priority granter; closes the loop on weighted round-robin arbitration.
- Consumes the one-hot `prior_grant` and registers it into a stable `grant` / `grant_valid` handshake toward the channel mux.
- Counts accepted grants per requester and drives `request_weight_completed` back into the granter.
- Opens a new weighting round once every active requester has used its weight.

Parameters:
- P_REQUESTER_NUM, 3, number of requesters; must equal the granter's P_REQUESTER_NUM.
- P_WEIGHT_W, 3, bit width of each requester's weight and grant counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- request  input  P_REQUESTER_NUM  raw request vector; the same vector feeds the granter.
- prior_grant  input  P_REQUESTER_NUM  one-hot (or zero) combinational grant from the granter.
- weight  input  P_REQUESTER_NUM*P_WEIGHT_W  packed weights; requester i uses bits [i*P_WEIGHT_W +: P_WEIGHT_W].
- grant_ready  input  1  downstream accepts the current grant.
- grant_valid  output  1  registered grant is valid.
- grant  output  P_REQUESTER_NUM  registered one-hot grant.
- request_weight_completed  output  P_REQUESTER_NUM  per-requester "weight used up this round"; drives the granter.

Behaviour:
- Reset (async, rst=1): state=IDLE, grant_valid=0, grant=0, all counters=0, request_weight_completed=0. Mid-handshake reset drops grant_valid immediately; the pending grant is not counted.
- FSM states: IDLE, BUSY.
- IDLE:
  - If prior_grant != 0: latch grant<=prior_grant, grant_valid<=1, go to BUSY.
  - Else: stay in IDLE, grant_valid=0.
- BUSY:
  - grant and grant_valid are held stable until a handshake (grant_valid & grant_ready). Changes on request or prior_grant are ignored.
  - On handshake: grant_valid<=0, grant<=0, go to IDLE.
- Latency and throughput:
  - prior_grant to grant_valid: 1 cycle.
  - One mandatory IDLE cycle after each handshake, so completed is updated before re-arbitration.
  - Maximum rate: 1 grant per 2 cycles.
- Weight accounting on handshake, for granted index k:
  - eff_w = (weight_k == 0) ? 1 : weight_k.
  - If completed[k]=0: cnt_k<=cnt_k+1. If cnt_k+1 >= eff_w, set completed_next[k]=1.
  - If completed[k]=1 (an exception grant from the granter): counter and flag are unchanged.
  - The >= compare makes a mid-round weight reduction complete on the next handshake. The counter never exceeds eff_w, so it never wraps.
- Round clear, evaluated on the handshake cycle only:
  - If (request & ~completed_next) == 0, then all counters<=0 and all completed<=0.
  - Otherwise completed<=completed_next.
- Requester drops its request: its count and completed flag persist until the round clear.
- prior_grant not one-hot in IDLE: a protocol violation. The lowest set bit is latched; the bench flags it with an assertion.
- Sole requester with weight 1: completed sets and the round clears on the same handshake, so the requester is re-granted every 2 cycles.

Decomposition:
- Shared arbiter package holds:
  - the packed-weight slice width;
  - state encodings (IDLE=1'b0, BUSY=1'b1);
  - the effective-weight rule as a function.
- One natural sub-module: `arb_weight_counter`. Per-requester counter plus completed flag, with inc, clear and eff_w inputs. It is instantiated P_REQUESTER_NUM times via generate.
- The FSM and round-clear logic stay in the top.

Test Plan:
- Reset during BUSY: request=3'b001, prior_grant=3'b001, grant_valid=1, grant_ready=0, assert rst → grant_valid=0, grant=0, completed=0 asynchronously, before the next edge.
- Hold stability: prior_grant=3'b010, grant_ready=0 for 5 cycles while prior_grant changes to 3'b100 → grant stays 3'b010 and grant_valid=1 throughout; handshake on cycle 6 → grant_valid=0 next cycle.
- Weighted round: weights {2,1,1}, request=3'b111, grant_ready=1, granter in loop → grant order 0,0,1,2, then completed returns to 3'b000 and the order repeats.
- Weight 0 treated as 1: weight_0=0, request=3'b001 → completed[0] set and round cleared on each handshake; a grant every 2 cycles.
- Exception grant: weights {1,3,1}, request=3'b011, requester 0 completed, requester 1 granted 3 times → after the 3rd handshake (request & ~completed)=0 → round clears and completed=3'b000.
- Dropped requester: request=3'b110, weights {1,1,1}, grant index 1; then request=3'b100 → completed[1] stays 1; round clears after requester 2's handshake.

Source files
------------

// File: rtl/arb_weight_tracker_pkg.sv
// ---------------------------------------------------------------------------
// arb_weight_tracker_pkg
// Shared definitions for the weighted round-robin tracking stage:
//   ARB_WEIGHT_W    - default width of one packed weight slice / grant counter
//   arb_state_e     - handshake FSM encoding (IDLE / BUSY)
//   arb_eff_weight  - effective-weight rule: a programmed weight of 0 counts
//                     as 1, so every requester gets at least one grant a round
// ---------------------------------------------------------------------------
package arb_weight_tracker_pkg;

  localparam int unsigned ARB_WEIGHT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Operates on a 32-bit container so callers of any slice width can use it;
  // the caller truncates the result back to its own width.
  function automatic logic [31:0] arb_eff_weight(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/arb_weight_counter.sv
// ---------------------------------------------------------------------------
// arb_weight_counter
// Per-requester grant counter plus "weight used up" flag.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   inc_i             - an accepted grant for this requester (handshake cycle)
//   clr_i             - round clear; wins over inc_i
//   eff_w_i           - effective weight (never 0)
//   completed_o       - registered completed flag
//   completed_next_o  - flag value this handshake would produce before any
//                       round clear; the top uses it to decide the clear
// ---------------------------------------------------------------------------
module arb_weight_counter #(
  parameter int unsigned P_WEIGHT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc_i,
  input  logic                  clr_i,
  input  logic [P_WEIGHT_W-1:0] eff_w_i,
  output logic                  completed_o,
  output logic                  completed_next_o
);

  logic [P_WEIGHT_W-1:0] cnt_q, cnt_d;
  logic                  completed_q, completed_d;
  logic [P_WEIGHT_W:0]   cnt_inc;
  logic                  reach;

  // One extra bit so the compare cannot be fooled by a wrap.
  assign cnt_inc = {1'b0, cnt_q} + (P_WEIGHT_W + 1)'(1);
  // ">=" rather than "==" so a weight lowered mid-round completes on the
  // very next accepted grant instead of counting past it.
  assign reach   = (cnt_inc >= {1'b0, eff_w_i});

  // A completed requester granted again (exception grant) keeps its flag.
  assign completed_next_o = completed_q | (inc_i & reach);
  assign completed_o      = completed_q;

  always_comb begin
    cnt_d       = cnt_q;
    completed_d = completed_q;
    if (clr_i) begin
      cnt_d       = '0;
      completed_d = 1'b0;
    end else if (inc_i && !completed_q) begin
      // Counting stops at completion, so the stored value never exceeds the
      // effective weight and the dropped carry bit is always zero here.
      cnt_d       = cnt_inc[P_WEIGHT_W-1:0];
      completed_d = reach;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      completed_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      completed_q <= completed_d;
    end
  end

endmodule

// File: rtl/arb_weight_tracker.sv
// ---------------------------------------------------------------------------
// arb_weight_tracker
// Registers the granter's one-hot grant into a valid/ready handshake toward
// the channel mux, counts accepted grants per requester and feeds the
// per-requester "weight used up" flags back to the granter. A new round
// opens when no still-requesting requester has weight left.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   request                   - raw request vector (same as the granter's)
//   prior_grant               - one-hot or zero combinational grant
//   weight                    - packed weights, requester i at [i*W +: W]
//   grant_ready               - downstream accepts the current grant
//   grant_valid               - registered grant is valid
//   grant                     - registered one-hot grant
//   request_weight_completed  - per-requester weight used up this round
// ---------------------------------------------------------------------------
module arb_weight_tracker
  import arb_weight_tracker_pkg::*;
#(
  parameter int unsigned P_REQUESTER_NUM = 3,
  parameter int unsigned P_WEIGHT_W      = ARB_WEIGHT_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [P_REQUESTER_NUM-1:0]            request,
  input  logic [P_REQUESTER_NUM-1:0]            prior_grant,
  input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] weight,
  input  logic                                 grant_ready,
  output logic                                 grant_valid,
  output logic [P_REQUESTER_NUM-1:0]            grant,
  output logic [P_REQUESTER_NUM-1:0]            request_weight_completed
);

  arb_state_e                 state_q, state_d;
  logic [P_REQUESTER_NUM-1:0] grant_q, grant_d;
  logic [P_REQUESTER_NUM-1:0] pg_lowest;
  logic [P_REQUESTER_NUM-1:0] inc;
  logic [P_REQUESTER_NUM-1:0] completed;
  logic [P_REQUESTER_NUM-1:0] completed_next;
  logic                       handshake;
  logic                       round_clr;

  // Isolate the lowest set bit so a malformed multi-hot grant still latches
  // a single requester.
  assign pg_lowest = prior_grant & ((~prior_grant) + P_REQUESTER_NUM'(1));

  assign handshake = (state_q == BUSY) && grant_ready;
  assign inc       = grant_q & {P_REQUESTER_NUM{handshake}};

  // Clear when every requester still asking has used its weight, counting
  // the grant being accepted right now.
  assign round_clr = handshake && ((request & ~completed_next) == '0);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (|prior_grant) begin
          state_d = BUSY;
          grant_d = pg_lowest;
        end
      end
      BUSY: begin
        // Returning to IDLE for one cycle lets the granter see the updated
        // completed flags before it is sampled again.
        if (grant_ready) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  for (genvar gi = 0; gi < P_REQUESTER_NUM; gi++) begin : g_cnt
    logic [P_WEIGHT_W-1:0] eff_w;

    assign eff_w = P_WEIGHT_W'(arb_eff_weight(32'(weight[gi*P_WEIGHT_W +: P_WEIGHT_W])));

    arb_weight_counter #(
      .P_WEIGHT_W (P_WEIGHT_W)
    ) u_cnt (
      .clk              (clk),
      .rst              (rst),
      .inc_i            (inc[gi]),
      .clr_i            (round_clr),
      .eff_w_i          (eff_w),
      .completed_o      (completed[gi]),
      .completed_next_o (completed_next[gi])
    );
  end

  assign grant_valid              = (state_q == BUSY);
  assign grant                    = grant_q;
  assign request_weight_completed = completed;

endmodule

// File: tb/tb_arb_weight_tracker.sv
// ---------------------------------------------------------------------------
// tb_arb_weight_tracker
// Table-driven vectors, hand-written corner sequences and a randomized run
// against a behavioural model of the weighted round-robin accounting.
// ---------------------------------------------------------------------------
module tb_arb_weight_tracker;

  localparam int N = 3;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   request;
  logic [N-1:0]   prior_grant;
  logic [N*W-1:0] weight;
  logic           grant_ready;
  logic           grant_valid;
  logic [N-1:0]   grant;
  logic [N-1:0]   request_weight_completed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_weight_tracker #(
    .P_REQUESTER_NUM (N),
    .P_WEIGHT_W      (W)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .request                  (request),
    .prior_grant              (prior_grant),
    .weight                   (weight),
    .grant_ready              (grant_ready),
    .grant_valid              (grant_valid),
    .grant                    (grant),
    .request_weight_completed (request_weight_completed)
  );

  // One line per accepted grant.
  always @(posedge clk) begin
    if (!rst && grant_valid && grant_ready)
      $display("txn t=%0t grant=%b req=%b completed=%b", $time, grant, request,
               request_weight_completed);
  end

  // The granter must hand over a one-hot (or zero) grant whenever it can be latched.
  always @(posedge clk) begin
    if (!rst && !grant_valid && prior_grant != '0)
      assert ($onehot(prior_grant))
      else $error("FAIL onehot prior_grant=%b", prior_grant);
  end

  // ---------------- behavioural reference model ----------------
  bit m_valid;
  int m_idx;
  int m_used [N];
  bit m_done [N];

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot_of(input int idx);
    logic [N-1:0] one;
    one = 1;
    return one << idx;
  endfunction

  // Reference granter: lowest requester with weight left, else lowest requester.
  function automatic logic [N-1:0] granter(input logic [N-1:0] req, input logic [N-1:0] done);
    logic [N-1:0] cand;
    cand = req & ~done;
    if (cand != '0) return onehot_of(lowest(cand));
    if (req != '0) return onehot_of(lowest(req));
    return '0;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_idx   = 0;
    for (int i = 0; i < N; i++) begin
      m_used[i] = 0;
      m_done[i] = 0;
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int ew;
    bit nd [N];
    bit all_used;
    if (m_valid && grant_ready) begin
      nd = m_done;
      ew = int'(weight[m_idx*W +: W]);
      if (ew == 0) ew = 1;
      if (!m_done[m_idx]) begin
        m_used[m_idx] = m_used[m_idx] + 1;
        if (m_used[m_idx] >= ew) nd[m_idx] = 1;
      end
      all_used = 1;
      for (int i = 0; i < N; i++) if (request[i] && !nd[i]) all_used = 0;
      if (all_used) begin
        for (int i = 0; i < N; i++) begin
          m_used[i] = 0;
          m_done[i] = 0;
        end
      end else begin
        m_done = nd;
      end
      m_valid = 0;
    end else if (!m_valid && prior_grant != '0) begin
      m_idx   = lowest(prior_grant);
      m_valid = 1;
    end
  endtask

  function automatic logic [N-1:0] model_done();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_done[i];
    return v;
  endfunction

  function automatic logic [N-1:0] model_grant();
    return m_valid ? onehot_of(m_idx) : '0;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]   req;
    logic [N-1:0]   pg;
    logic [N*W-1:0] w;
    logic           rdy;
    logic           exp_v;
    logic [N-1:0]   exp_g;
    logic [N-1:0]   exp_c;
  } vec_t;

  localparam logic [N*W-1:0] W111 = 9'b001_001_001;
  localparam logic [N*W-1:0] WZ   = 9'b001_001_000; // weight_0 = 0
  localparam logic [N*W-1:0] WE   = 9'b001_011_001; // {1,3,1}
  localparam logic [N*W-1:0] WR1  = 9'b001_001_011; // weight_0 = 3
  localparam logic [N*W-1:0] W211 = 9'b001_001_010; // {2,1,1}

  vec_t tbl [$];
  int   order [$];

  initial begin
    int exp_order [8];
    int hs_cnt;
    bit prev_v;
    int budget;

    rst         = 1'b1;
    request     = '0;
    prior_grant = '0;
    weight      = W111;
    grant_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(grant_valid), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_completed", 32'(request_weight_completed), 32'd0);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    // dropped requester
    tbl.push_back('{3'b110, 3'b010, W111, 1'b0, 1'b1, 3'b010, 3'b000});
    tbl.push_back('{3'b110, 3'b010, W111, 1'b1, 1'b0, 3'b000, 3'b010});
    tbl.push_back('{3'b100, 3'b100, W111, 1'b0, 1'b1, 3'b100, 3'b010});
    tbl.push_back('{3'b100, 3'b000, W111, 1'b1, 1'b0, 3'b000, 3'b000});
    tbl.push_back('{3'b100, 3'b100, W111, 1'b1, 1'b1, 3'b100, 3'b000});
    tbl.push_back('{3'b100, 3'b000, W111, 1'b1, 1'b0, 3'b000, 3'b000});
    // weight 0 behaves as 1: sole requester re-granted every 2 cycles
    tbl.push_back('{3'b001, 3'b001, WZ, 1'b1, 1'b1, 3'b001, 3'b000});
    tbl.push_back('{3'b001, 3'b001, WZ, 1'b1, 1'b0, 3'b000, 3'b000});
    tbl.push_back('{3'b001, 3'b001, WZ, 1'b1, 1'b1, 3'b001, 3'b000});
    tbl.push_back('{3'b001, 3'b001, WZ, 1'b1, 1'b0, 3'b000, 3'b000});
    // exception grant and weight-3 requester
    tbl.push_back('{3'b011, 3'b001, WE, 1'b1, 1'b1, 3'b001, 3'b000});
    tbl.push_back('{3'b011, 3'b001, WE, 1'b1, 1'b0, 3'b000, 3'b001});
    tbl.push_back('{3'b011, 3'b001, WE, 1'b1, 1'b1, 3'b001, 3'b001});
    tbl.push_back('{3'b011, 3'b010, WE, 1'b1, 1'b0, 3'b000, 3'b001});
    tbl.push_back('{3'b011, 3'b010, WE, 1'b1, 1'b1, 3'b010, 3'b001});
    tbl.push_back('{3'b011, 3'b010, WE, 1'b1, 1'b0, 3'b000, 3'b001});
    tbl.push_back('{3'b011, 3'b010, WE, 1'b1, 1'b1, 3'b010, 3'b001});
    tbl.push_back('{3'b011, 3'b010, WE, 1'b1, 1'b0, 3'b000, 3'b001});
    tbl.push_back('{3'b011, 3'b010, WE, 1'b1, 1'b1, 3'b010, 3'b001});
    tbl.push_back('{3'b011, 3'b010, WE, 1'b1, 1'b0, 3'b000, 3'b000});
    // weight reduced mid-round completes on the next handshake
    tbl.push_back('{3'b011, 3'b001, WR1,  1'b1, 1'b1, 3'b001, 3'b000});
    tbl.push_back('{3'b011, 3'b001, WR1,  1'b1, 1'b0, 3'b000, 3'b000});
    tbl.push_back('{3'b011, 3'b001, W111, 1'b1, 1'b1, 3'b001, 3'b000});
    tbl.push_back('{3'b011, 3'b001, W111, 1'b1, 1'b0, 3'b000, 3'b001});
    tbl.push_back('{3'b011, 3'b010, W111, 1'b1, 1'b1, 3'b010, 3'b001});
    tbl.push_back('{3'b011, 3'b010, W111, 1'b1, 1'b0, 3'b000, 3'b000});

    for (int v = 0; v < tbl.size(); v++) begin
      request     = tbl[v].req;
      prior_grant = tbl[v].pg;
      weight      = tbl[v].w;
      grant_ready = tbl[v].rdy;
      tick();
      $display("vec %0d req=%b pg=%b rdy=%b -> v=%b g=%b c=%b", v, tbl[v].req, tbl[v].pg,
               tbl[v].rdy, grant_valid, grant, request_weight_completed);
      check($sformatf("vec%0d_valid", v), 32'(grant_valid), 32'(tbl[v].exp_v));
      check($sformatf("vec%0d_grant", v), 32'(grant), 32'(tbl[v].exp_g));
      check($sformatf("vec%0d_completed", v), 32'(request_weight_completed), 32'(tbl[v].exp_c));
    end

    // ---------------- reset during BUSY ----------------
    do_reset();
    weight      = W111;
    request     = 3'b011;
    prior_grant = 3'b001;
    grant_ready = 1'b1;
    tick();
    tick();
    grant_ready = 1'b0;
    prior_grant = 3'b010;
    tick();
    check("prerst_valid", 32'(grant_valid), 32'd1);
    check("prerst_completed", 32'(request_weight_completed), 32'b001);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("asyncrst_valid", 32'(grant_valid), 32'd0);
    check("asyncrst_grant", 32'(grant), 32'd0);
    check("asyncrst_completed", 32'(request_weight_completed), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---------------- hold stability ----------------
    request     = 3'b010;
    prior_grant = 3'b010;
    grant_ready = 1'b0;
    tick();
    check("hold_first_grant", 32'(grant), 32'b010);
    prior_grant = 3'b100;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("hold%0d_grant", c), 32'(grant), 32'b010);
      check($sformatf("hold%0d_valid", c), 32'(grant_valid), 32'd1);
    end
    grant_ready = 1'b1;
    prior_grant = 3'b000;
    tick();
    check("hold_hs_valid", 32'(grant_valid), 32'd0);
    check("hold_hs_grant", 32'(grant), 32'd0);
    check("hold_hs_completed", 32'(request_weight_completed), 32'd0);

    // ---------------- weighted round, granter in the loop ----------------
    do_reset();
    weight      = W211;
    request     = 3'b111;
    grant_ready = 1'b1;
    exp_order   = '{0, 0, 1, 2, 0, 0, 1, 2};
    order.delete();
    hs_cnt = 0;
    budget = 0;
    while (order.size() < 8 && budget < 40) begin
      prior_grant = granter(request, request_weight_completed);
      prev_v = grant_valid;
      tick();
      budget++;
      if (grant_valid && !prev_v) order.push_back(lowest(grant));
      if (prev_v && !grant_valid) begin
        hs_cnt++;
        if (hs_cnt == 2) check("wrr_completed_after2", 32'(request_weight_completed), 32'b001);
        if (hs_cnt == 4) check("wrr_completed_after4", 32'(request_weight_completed), 32'b000);
      end
    end
    check("wrr_grant_count", 32'(order.size()), 32'd8);
    for (int i = 0; i < order.size(); i++)
      check($sformatf("wrr_order%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // ---------------- randomized run against the model ----------------
    do_reset();
    weight = W111;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) weight = N*W'($urandom);
      if ($urandom_range(0, 3) == 0) request = N'($urandom);
      grant_ready = 1'($urandom);
      if ($urandom_range(0, 4) == 0)
        prior_grant = ($urandom_range(0, 3) == 0) ? '0 : onehot_of(int'($urandom_range(0, N-1)));
      else
        prior_grant = granter(request, model_done());
      tick();
      check($sformatf("rnd%0d_valid", c), 32'(grant_valid), 32'(m_valid));
      check($sformatf("rnd%0d_grant", c), 32'(grant), 32'(model_grant()));
      check($sformatf("rnd%0d_completed", c), 32'(request_weight_completed), 32'(model_done()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
